// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// mips_ctrl_pkg: state, opcode, funct and control-field encodings shared by the
// multi-cycle MIPS controller.  Revision 1.0
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_MEM_WB    = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_I_EXEC    = 4'd9,
    S_I_WB      = 4'd10,
    S_BRANCH    = 4'd11,
    S_JUMP      = 4'd12,
    S_JAL       = 4'd13,
    S_JR        = 4'd14,
    S_FAULT     = 4'd15
  } state_e;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_SLTI   = 6'b001010;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_XORI   = 6'b001110;
  localparam logic [5:0] OP_LB     = 6'b100000;
  localparam logic [5:0] OP_LH     = 6'b100001;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SB     = 6'b101000;
  localparam logic [5:0] OP_SH     = 6'b101001;
  localparam logic [5:0] OP_SW     = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_MULT = 6'b011000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  localparam logic [4:0] RT_BLTZ = 5'b00000;
  localparam logic [4:0] RT_BGEZ = 5'b00001;

  localparam logic [4:0] ALU_NONE = 5'b00000;
  localparam logic [4:0] ALU_ADD  = 5'b00001;
  localparam logic [4:0] ALU_SUB  = 5'b00010;
  localparam logic [4:0] ALU_MULT = 5'b00011;
  localparam logic [4:0] ALU_SLL  = 5'b00100;
  localparam logic [4:0] ALU_SRL  = 5'b00101;
  localparam logic [4:0] ALU_AND  = 5'b00110;
  localparam logic [4:0] ALU_OR   = 5'b00111;
  localparam logic [4:0] ALU_XOR  = 5'b01000;
  localparam logic [4:0] ALU_BEQ  = 5'b01100;
  localparam logic [4:0] ALU_NOR  = 5'b01101;
  localparam logic [4:0] ALU_SLT  = 5'b01110;
  localparam logic [4:0] ALU_BNE  = 5'b01111;
  localparam logic [4:0] ALU_BGTZ = 5'b10000;
  localparam logic [4:0] ALU_BLEZ = 5'b10001;

  localparam logic [1:0] MSZ_WORD = 2'b00;
  localparam logic [1:0] MSZ_HALF = 2'b01;
  localparam logic [1:0] MSZ_BYTE = 2'b10;

  localparam logic [1:0] PCS_INC    = 2'b00;
  localparam logic [1:0] PCS_BRANCH = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_REG    = 2'b11;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MDR = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  // Access width comes from the low two opcode bits of loads and stores.
  function automatic logic [1:0] mem_size(input logic [5:0] op);
    case (op[1:0])
      2'b11:   return MSZ_WORD;
      2'b01:   return MSZ_HALF;
      default: return MSZ_BYTE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_op_decoder.sv
`default_nettype none
// alu_op_decoder: maps opcode/funct/rt to the 5-bit ALUControl code and flags
// encodings the controller does not support.  Revision 1.0
module alu_op_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic [4:0] rt_i,
  output logic [4:0] alu_code_o,
  output logic       valid_o
);

  always_comb begin
    alu_code_o = ALU_NONE;
    valid_o    = 1'b1;
    case (opcode_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_ADD:  alu_code_o = ALU_ADD;
          FN_SUB:  alu_code_o = ALU_SUB;
          FN_MULT: alu_code_o = ALU_MULT;
          FN_SLL:  alu_code_o = ALU_SLL;
          FN_SRL:  alu_code_o = ALU_SRL;
          FN_AND:  alu_code_o = ALU_AND;
          FN_OR:   alu_code_o = ALU_OR;
          FN_XOR:  alu_code_o = ALU_XOR;
          FN_NOR:  alu_code_o = ALU_NOR;
          FN_SLT:  alu_code_o = ALU_SLT;
          FN_JR:   alu_code_o = ALU_NONE;
          default: valid_o    = 1'b0;
        endcase
      end
      OP_LB, OP_LH, OP_LW, OP_SB, OP_SH, OP_SW: alu_code_o = ALU_ADD;
      OP_ADDI: alu_code_o = ALU_ADD;
      OP_ANDI: alu_code_o = ALU_AND;
      OP_ORI:  alu_code_o = ALU_OR;
      OP_XORI: alu_code_o = ALU_XOR;
      OP_SLTI: alu_code_o = ALU_SLT;
      OP_BEQ:  alu_code_o = ALU_BEQ;
      OP_BNE:  alu_code_o = ALU_BNE;
      OP_BGTZ: alu_code_o = ALU_BGTZ;
      OP_BLEZ: alu_code_o = ALU_BLEZ;
      // bltz shares the beq compare, bgez shares the bne compare
      OP_REGIMM: begin
        if (rt_i == RT_BLTZ)      alu_code_o = ALU_BEQ;
        else if (rt_i == RT_BGEZ) alu_code_o = ALU_BNE;
        else                      valid_o    = 1'b0;
      end
      OP_J, OP_JAL: alu_code_o = ALU_NONE;
      default: valid_o = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// multicycle_controller: multi-cycle MIPS control FSM with memory-ready
// handshake, access timeout and sticky fault.  Revision 1.0
module multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Instruction,
  input  logic        BranchCond,
  input  logic        MemReady,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [1:0]  MemSize,
  output logic        RegWrite,
  output logic [1:0]  RegDst,
  output logic [1:0]  MemToReg,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSource,
  output logic [4:0]  ALUControl,
  output logic        Fault,
  output logic [3:0]  State
);

  localparam int             CW        = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0]  CNT_LIMIT = CW'(MEM_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [5:0]      w_opcode;
  logic [4:0]      w_alu_code;
  logic            w_alu_valid;

  assign w_opcode = Instruction[31:26];

  alu_op_decoder u_alu_dec (
    .opcode_i   (w_opcode),
    .funct_i    (Instruction[5:0]),
    .rt_i       (Instruction[20:16]),
    .alu_code_o (w_alu_code),
    .valid_o    (w_alu_valid)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The wait counter only survives while a memory state keeps waiting, so
  // every entry into FETCH/MEM_READ/MEM_WRITE starts it from zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH, S_MEM_READ, S_MEM_WRITE: begin
        if (MemReady) begin
          if (state_q == S_FETCH)         state_d = S_DECODE;
          else if (state_q == S_MEM_READ) state_d = S_MEM_WB;
          else                            state_d = S_FETCH;
        end else if (cnt_q == CNT_LIMIT) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DECODE: begin
        if (Instruction == 32'd0) begin
          state_d = S_FETCH;
        end else if (!w_alu_valid) begin
          state_d = S_FAULT;
        end else begin
          case (w_opcode)
            OP_RTYPE: state_d = (Instruction[5:0] == FN_JR) ? S_JR : S_R_EXEC;
            OP_LB, OP_LH, OP_LW, OP_SB, OP_SH, OP_SW: state_d = S_MEM_ADDR;
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: state_d = S_I_EXEC;
            OP_BEQ, OP_BNE, OP_BGTZ, OP_BLEZ, OP_REGIMM: state_d = S_BRANCH;
            OP_J:    state_d = S_JUMP;
            OP_JAL:  state_d = S_JAL;
            default: state_d = S_FAULT;
          endcase
        end
      end
      // Store opcodes are the 101xxx group; opcode bit 3 separates them.
      S_MEM_ADDR: state_d = Instruction[29] ? S_MEM_WRITE : S_MEM_READ;
      S_R_EXEC:   state_d = S_R_WB;
      S_I_EXEC:   state_d = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP, S_JAL, S_JR: state_d = S_FETCH;
      S_FAULT:    state_d = S_FAULT;
      default:    state_d = S_FAULT;
    endcase
  end

  always_comb begin
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    MemSize    = MSZ_WORD;
    RegWrite   = 1'b0;
    RegDst     = RD_RT;
    MemToReg   = M2R_ALU;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_RT;
    PCSource   = PCS_INC;
    ALUControl = ALU_NONE;
    Fault      = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead    = 1'b1;
        ALUSrcB    = SRCB_FOUR;
        ALUControl = ALU_ADD;
        PCWrite    = MemReady;
        IRWrite    = MemReady;
      end
      S_DECODE: begin
        ALUSrcB    = SRCB_IMM;
        ALUControl = ALU_ADD;
      end
      S_MEM_ADDR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
        ALUControl = ALU_ADD;
      end
      S_MEM_READ: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        MemSize = mem_size(w_opcode);
      end
      S_MEM_WRITE: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        MemSize  = mem_size(w_opcode);
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemToReg = M2R_MDR;
      end
      S_R_EXEC: begin
        ALUSrcA    = 1'b1;
        ALUControl = w_alu_code;
      end
      S_R_WB: begin
        RegWrite   = 1'b1;
        RegDst     = RD_RD;
        ALUControl = w_alu_code;
      end
      S_I_EXEC: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
        ALUControl = w_alu_code;
      end
      S_I_WB: begin
        RegWrite   = 1'b1;
        ALUControl = w_alu_code;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        PCSource   = PCS_BRANCH;
        PCWrite    = BranchCond;
        ALUControl = w_alu_code;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCS_JUMP;
      end
      S_JAL: begin
        PCWrite  = 1'b1;
        PCSource = PCS_JUMP;
        RegWrite = 1'b1;
        RegDst   = RD_RA;
        MemToReg = M2R_PC;
      end
      S_JR: begin
        PCWrite  = 1'b1;
        PCSource = PCS_REG;
      end
      S_FAULT: Fault = 1'b1;
      default: ;
    endcase
  end

  assign State = state_q;

endmodule
`default_nettype wire

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle MIPS control FSM that sequences the shared datapath: PC, instruction register, register file, ALU and a single unified memory port.
- Runs each instruction through fetch, decode, execute, memory and writeback steps, and waits on a memory ready handshake.
- Decodes opcode/funct into the team's 5-bit ALUControl codes.
- Enters a sticky fault state on an illegal instruction or a memory timeout.

Parameters:
MEM_TIMEOUT, 16, max cycles a memory access may wait for MemReady before FAULT (≥1)

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  synchronous, active-low reset
Instruction  in  32  current instruction register contents
BranchCond  in  1  ALU branch-condition result; 1 = take branch
MemReady  in  1  memory completes the current access this cycle
PCWrite  out  1  load PC this cycle
IRWrite  out  1  load instruction register
IorD  out  1  memory address source: 0 = PC, 1 = ALUOut
MemRead  out  1  memory read strobe
MemWrite  out  1  memory write strobe
MemSize  out  2  00 = word, 01 = half, 10 = byte
RegWrite  out  1  register file write enable
RegDst  out  2  00 = rt, 01 = rd, 10 = $31
MemToReg  out  2  00 = ALUOut, 01 = MDR, 10 = PC
ALUSrcA  out  1  0 = PC, 1 = rs
ALUSrcB  out  2  00 = rt, 01 = const 4, 10 = sign-extended immediate
PCSource  out  2  00 = PC+4, 01 = branch target, 10 = jump target, 11 = rs
ALUControl  out  5  ALU operation code
Fault  out  1  sticky fault flag
State  out  4  current state, for debug

Behaviour:
- Reset:
  - Reset=0 at a rising edge puts state in IDLE and clears the timeout counter; this applies in any state, including mid-access.
  - In IDLE every output is 0.
  - IDLE goes to FETCH on the next cycle after Reset=1.
- Output model: all outputs are Moore, decoded from the state; ALUControl, MemSize and PCWrite in BRANCH also use Instruction and BranchCond. Outputs not listed for a state are 0.
- FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=00001.
  - On MemReady=1: PCWrite=1, IRWrite=1, PCSource=00, and go to DECODE.
  - Otherwise stay in FETCH.
- DECODE (ALUSrcA=0, ALUSrcB=10, ALUControl=00001; precomputes the branch target) routes by opcode:
  - 000000: R_EXEC, except all-zero Instruction, which is a nop and goes to FETCH; funct 001000 goes to JR.
  - 100011 / 100001 / 100000: MEM_ADDR (loads).
  - 101011 / 101001 / 101000: MEM_ADDR (stores).
  - 001000 / 001100 / 001101 / 001110 / 001010: I_EXEC.
  - 000100 / 000101 / 000001 / 000111 / 000110: BRANCH.
  - 000010: JUMP.
  - 000011: JAL.
  - Any other opcode: FAULT.
- ALU codes:
  - add 00001, sub 00010, mult 00011, sll 00100, srl 00101, and 00110, or 00111, xor 01000, nor 01101, slt 01110.
  - beq/bltz 01100, bne/bgez 01111, bgtz 10000, blez 10001.
  - Unknown R-type funct goes to FAULT.
- R_EXEC: ALUSrcA=1, ALUSrcB=00; next state R_WB.
- R_WB: RegWrite=1, RegDst=01, MemToReg=00; next state FETCH.
- I_EXEC: ALUSrcA=1, ALUSrcB=10; next state I_WB.
- I_WB: RegWrite=1, RegDst=00, MemToReg=00; next state FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUControl=00001; next state MEM_READ (loads) or MEM_WRITE (stores).
- MEM_READ / MEM_WRITE:
  - Outputs: IorD=1, MemRead=1 or MemWrite=1, MemSize from opcode (x11 = word, x01 = half, x00 = byte).
  - Strobes stay asserted until MemReady=1.
  - On MemReady: MEM_READ goes to MEM_WB; MEM_WRITE goes to FETCH.
- MEM_WB: RegWrite=1, RegDst=00, MemToReg=01; next state FETCH.
- BRANCH:
  - ALUSrcA=1, ALUSrcB=00, PCSource=01, PCWrite=BranchCond.
  - Opcode 000001 selects on Instruction[20:16]: 00001 = bgez, 00000 = bltz, other = FAULT.
  - Next state FETCH.
- JUMP: PCWrite=1, PCSource=10; next state FETCH.
- JAL: PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemToReg=10. The link value is the already-incremented PC; there is no delay slot. Next state FETCH.
- JR: PCWrite=1, PCSource=11; next state FETCH.
- Timeout:
  - The counter clears on entry to FETCH, MEM_READ or MEM_WRITE and increments each waiting cycle.
  - Reaching MEM_TIMEOUT with MemReady=0 goes to FAULT.
  - MemReady arriving in the same cycle the counter reaches the limit wins.
- FAULT: Fault=1, all strobes 0; exits only via Reset.
- Latency with MemReady=1 immediately: R/I/store 4 cycles, load 5, branch/jump 3.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode and funct constants;
  - ALUControl codes;
  - state encoding: IDLE=0, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WRITE, MEM_WB, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP, JAL, JR, FAULT=15;
  - MemSize / PCSource / RegDst encodings.
- Sub-module alu_op_decoder: combinational map from opcode, funct and rt to ALUControl plus a valid flag; the FSM uses the valid flag for its FAULT decisions.

Test Plan:
- Add 0x00221820, MemReady=1 → states FETCH, DECODE, R_EXEC, R_WB; R_WB has RegWrite=1, RegDst=01, ALUControl=00001; back in FETCH on cycle 5.
- Load 0x8C220004, MemReady low for 3 cycles in MEM_READ → MemRead and IorD held for 4 cycles; MEM_WB has MemToReg=01, MemSize=00.
- Branch 0x10220003 (beq):
  - BranchCond=1 → PCWrite=1, PCSource=01, ALUControl=01100.
  - BranchCond=0 → PCWrite=0.
- Jump 0x0C000010 (jal) → one cycle with PCWrite=1, RegWrite=1, RegDst=10, MemToReg=10.
- Timeout: MemReady=0 for 16 cycles in FETCH → FAULT with Fault=1. Opcode 0x3F → FAULT after DECODE.
- Reset=0 asserted in MEM_WRITE → next cycle IDLE with MemWrite=0 and Fault=0; FETCH one cycle after release.
